// File: rtl/countdown_timer4_if.sv
// Command/status bundle for countdown_timer4: start/stop/enable/mode controls in,
// registered count and status flags out.
interface countdown_timer4_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             periodic;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load_val, start, stop, en, periodic,
    input  out, busy, tc, done
  );

  modport slave (
    input  load_val, start, stop, en, periodic,
    output out, busy, tc, done
  );
endinterface

// File: rtl/countdown_timer4.sv
// Loadable down-counter with one-shot and periodic (auto-reload) modes.
// Emits a one-cycle terminal-count pulse; done latches one-shot completion.
module countdown_timer4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  countdown_timer4_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             mode, mode_n;
  logic             tc_q, tc_n;
  logic             done_q, done_n;
  logic             load_zero;

  assign load_zero = (bus.load_val == WIDTH'(0));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      mode   <= 1'b0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      mode   <= mode_n;
      tc_q   <= tc_n;
      done_q <= done_n;
    end
  end

  // Next-state: stop beats start beats counting in every state
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    mode_n   = mode;
    tc_n     = 1'b0;
    done_n   = done_q;

    if (bus.stop) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end else if (bus.start) begin
      // A zero load completes immediately so periodic mode cannot spin on a zero period
      if (load_zero) begin
        cnt_n   = '0;
        tc_n    = 1'b1;
        done_n  = 1'b1;
        state_n = DONE;
      end else begin
        reload_n = bus.load_val;
        mode_n   = bus.periodic;
        cnt_n    = bus.load_val;
        done_n   = 1'b0;
        state_n  = RUN;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (bus.en) begin
            if (cnt > WIDTH'(1)) begin
              cnt_n = cnt - WIDTH'(1);
            end else begin
              tc_n = 1'b1;
              if (mode) begin
                cnt_n = reload;
              end else begin
                cnt_n   = '0;
                done_n  = 1'b1;
                state_n = DONE;
              end
            end
          end
        end
        DONE: begin
          cnt_n = '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out  = cnt;
  assign bus.tc   = tc_q;
  assign bus.done = done_q;
  assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer4.sv
// Directed, table-driven bench for countdown_timer4 plus hand-written
// sequences for asynchronous reset and the full-scale countdown.
module tb_countdown_timer4;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  countdown_timer4_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       en;
    logic       periodic;
    logic [3:0] load_val;
    logic [3:0] exp_out;
    logic       exp_busy;
    logic       exp_tc;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic s, input logic p, input logic e,
                              input logic per, input logic [3:0] lv, input logic [3:0] eo,
                              input logic eb, input logic et, input logic ed);
    vec_t v;
    v.name = n; v.start = s; v.stop = p; v.en = e; v.periodic = per; v.load_val = lv;
    v.exp_out = eo; v.exp_busy = eb; v.exp_tc = et; v.exp_done = ed;
    return v;
  endfunction

  task automatic drive(input logic s, input logic p, input logic e, input logic per,
                       input logic [3:0] lv);
    bus.start = s; bus.stop = p; bus.en = e; bus.periodic = per; bus.load_val = lv;
  endtask

  task automatic check(input string name, input logic [3:0] eo, input logic eb,
                       input logic et, input logic ed);
    total++;
    if ({bus.out, bus.busy, bus.tc, bus.done} === {eo, eb, et, ed}) begin
      passed++;
    end else begin
      $display("FAIL %s: got out=%0d busy=%b tc=%b done=%b, expected out=%0d busy=%b tc=%b done=%b",
               name, bus.out, bus.busy, bus.tc, bus.done, eo, eb, et, ed);
    end
  endtask

  task automatic step_check(input string name, input logic [3:0] eo, input logic eb,
                            input logic et, input logic ed);
    @(posedge clk);
    #1;
    check(name, eo, eb, et, ed);
  endtask

  initial begin
    // start stop en per ld -> out busy tc done
    vecs.push_back(mk("os_load5",   1, 0, 1, 0, 5, 5, 1, 0, 0));
    vecs.push_back(mk("os_4",       0, 0, 1, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk("os_3",       0, 0, 1, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk("os_2",       0, 0, 1, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("os_1",       0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("os_tc",      0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("os_held",    0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("os_stop",    0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("per_load3",  1, 0, 1, 1, 3, 3, 1, 0, 0));
    for (int r = 0; r < 4; r++) begin
      vecs.push_back(mk($sformatf("per_r%0d_2", r),  0, 0, 1, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk($sformatf("per_r%0d_1", r),  0, 0, 1, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk($sformatf("per_r%0d_tc", r), 0, 0, 1, 0, 0, 3, 1, 1, 0));
    end
    vecs.push_back(mk("stop_start", 1, 1, 1, 0, 9, 3, 0, 0, 0));
    vecs.push_back(mk("hold_load6", 1, 0, 1, 0, 6, 6, 1, 0, 0));
    vecs.push_back(mk("hold_5",     0, 0, 1, 0, 0, 5, 1, 0, 0));
    vecs.push_back(mk("hold_4",     0, 0, 1, 0, 0, 4, 1, 0, 0));
    for (int h = 0; h < 4; h++)
      vecs.push_back(mk($sformatf("hold_en0_%0d", h), 0, 0, 0, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk("restart2",   1, 0, 1, 0, 2, 2, 1, 0, 0));
    vecs.push_back(mk("restart_1",  0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("restart_tc", 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("zero_done",  1, 0, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("zero_held",  0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("zero_stop",  0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("zero_idle",  1, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("zero_clr",   0, 1, 0, 0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].periodic, vecs[i].load_val);
      step_check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_tc, vecs[i].exp_done);
    end

    // Full-scale one-shot: 15 down to 0 with no wrap, tc only on the last step
    drive(1, 0, 1, 0, 15);
    step_check("max_load", 15, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    for (int k = 14; k >= 1; k--)
      step_check($sformatf("max_%0d", k), 4'(k), 1, 0, 0);
    step_check("max_tc", 0, 0, 1, 1);
    step_check("max_nowrap", 0, 0, 0, 1);

    // Asynchronous reset mid-count at out=9
    drive(1, 0, 1, 1, 9);
    step_check("rst_load9", 9, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    step_check("rst_idle", 0, 0, 0, 0);
    step_check("rst_idle2", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
